// File: rtl/riscv_ifu.sv
// Instruction fetch unit: fetches one word per PC on a single-outstanding imem port.
// The fetched word goes to decode over valid/ready, and pc_we_o fires only when decode takes it.
//
// state | meaning
// IDLE  | waiting for a stable PC
// REQ   | read request presented to imem
// WAIT  | request accepted, waiting for the response
// VALID | instruction (or fault) offered to decode
// DRAIN | flushed after acceptance; swallow the one pending response
module riscv_ifu #(
    parameter logic [31:0] RESET_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        pc_valid_i,
    input  logic        flush_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_rsp_err_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_fault_o,
    output logic        pc_we_o
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic [31:0] inst_q;
    logic        fault_q;
    logic        load_pc;
    logic        load_misal;
    logic        load_rsp;

    always_comb begin
        state_nxt  = state;
        load_pc    = 1'b0;
        load_misal = 1'b0;
        load_rsp   = 1'b0;
        case (state)
            IDLE: begin
                if (!flush_i && pc_valid_i) begin
                    load_pc = 1'b1;
                    if (pc_i[1:0] != 2'b00) begin
                        load_misal = 1'b1;
                        state_nxt  = VALID;
                    end else begin
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                // An accepted request still owes a response, so a flush must drain it.
                if (flush_i)
                    state_nxt = imem_req_ready_i ? DRAIN : IDLE;
                else if (imem_req_ready_i)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (flush_i) begin
                    state_nxt = imem_rsp_valid_i ? IDLE : DRAIN;
                end else if (imem_rsp_valid_i) begin
                    load_rsp  = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (flush_i || inst_ready_i)
                    state_nxt = IDLE;
            end
            DRAIN: begin
                if (imem_rsp_valid_i)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            addr_q  <= 32'h0;
            inst_q  <= RESET_INST;
            fault_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_pc)
                addr_q <= pc_i;
            if (load_misal) begin
                inst_q  <= RESET_INST;
                fault_q <= 1'b1;
            end
            if (load_rsp) begin
                inst_q  <= imem_rsp_err_i ? RESET_INST : imem_rdata_i;
                fault_q <= imem_rsp_err_i;
            end
        end
    end

    assign imem_req_valid_o = (state == REQ);
    assign imem_addr_o      = {addr_q[31:2], 2'b00};
    assign inst_valid_o     = (state == VALID);
    assign inst_o           = inst_q;
    assign inst_pc_o        = addr_q;
    assign inst_fault_o     = fault_q && (state == VALID);
    assign pc_we_o          = (state == VALID) && inst_ready_i && !flush_i;

endmodule

// File: doc/riscv_ifu.md
# riscv_ifu

Instruction fetch unit for the NPC core: takes the current PC from the next-PC logic, issues a single-outstanding read on the instruction-memory request/response interface, and presents the fetched word to decode with a valid/ready handshake. It is the consumer side of the PC interface. It pulses `pc_we_o` when decode accepts an instruction, so the PC register advances only on consumed fetches. It supports flush with proper dropping of in-flight responses.

## Interface
- `RESET_INST`, 32'h0000_0000: value driven on `inst_o` at reset and on fault.
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pc_i`  in  32  fetch address from the PC register.
- `pc_valid_i`  in  1  PC is stable and a fetch may start.
- `flush_i`  in  1  discard current fetch (redirect); one-cycle pulse or level.
- `imem_req_valid_o`  out  1  read request valid.
- `imem_req_ready_i`  in  1  memory accepts the request.
- `imem_addr_o`  out  32  read address, word aligned.
- `imem_rsp_valid_i`  in  1  read data valid; exactly one per accepted request.
- `imem_rdata_i`  in  32  read data.
- `imem_rsp_err_i`  in  1  bus error, qualified by `imem_rsp_valid_i`.
- `inst_valid_o`  out  1  instruction available to decode.
- `inst_ready_i`  in  1  decode accepts the instruction.
- `inst_o`  out  32  instruction word.
- `inst_pc_o`  out  32  PC of `inst_o`.
- `inst_fault_o`  out  1  fetch fault: misaligned PC or bus error.
- `pc_we_o`  out  1  one-cycle PC-advance strobe.

## Operation
- FSM states: IDLE, REQ, WAIT, VALID, DRAIN. Reset enters IDLE.
- Reset values: all `*_valid_o`, `pc_we_o`, and `inst_fault_o` are 0. `imem_addr_o` and `inst_pc_o` are 0. `inst_o` is `RESET_INST`.
- IDLE, with `pc_valid_i` high and no flush:
  - Latch `pc_i` into the address register.
  - If `pc_i[1:0]` is nonzero: go to VALID with `inst_fault_o`=1 and `inst_o`=`RESET_INST`. No memory request is issued.
  - Otherwise: go to REQ.
- REQ:
  - `imem_req_valid_o`=1, `imem_addr_o`=latched PC.
  - On `imem_req_ready_i`, go to WAIT. Otherwise hold, with address stable.
- WAIT:
  - On `imem_rsp_valid_i`, capture `imem_rdata_i` into `inst_o` and `imem_rsp_err_i` into `inst_fault_o`, then go to VALID.
  - On error, `inst_o`=`RESET_INST`.
- VALID:
  - `inst_valid_o`=1. `inst_o`, `inst_pc_o`, and `inst_fault_o` are held stable until the handshake completes.
  - On `inst_valid_o && inst_ready_i`: `pc_we_o`=1 combinationally in that cycle, and the next state is IDLE.
- Flush, which has priority over every other event in the same cycle:
  - From IDLE or VALID: go to IDLE. No `pc_we_o`, even if `inst_ready_i` is high.
  - From REQ, with `imem_req_ready_i` high that cycle: go to DRAIN (request was accepted). Otherwise go to IDLE; withdrawing the request is legal.
  - From WAIT, with `imem_rsp_valid_i` high that cycle: discard the data and go to IDLE. Otherwise go to DRAIN.
  - DRAIN: ignore `flush_i`. The first `imem_rsp_valid_i` is discarded, then go to IDLE. No output is ever produced for a drained fetch.
- `imem_rsp_valid_i` in IDLE, REQ, or VALID is a protocol error and is ignored.
- At most one request is outstanding at any time.

## Timing
- Minimum fetch latency: `pc_valid_i` sampled in IDLE at cycle 0.
  - REQ at cycle 1; ready in that same cycle.
  - WAIT at cycle 2; response in that same cycle.
  - VALID at cycle 3. Handshake at cycle 3 pulses `pc_we_o` at cycle 3; the PC register updates at the cycle 4 edge; IDLE at cycle 4.
  - Throughput is therefore one instruction per 4 cycles at best.
- Misaligned PC: VALID at cycle 1, no memory traffic.
- `pc_we_o` is high for exactly one cycle per consumed instruction, including faulted ones.
- Asynchronous reset mid-fetch returns to IDLE immediately. An in-flight memory response arriving after reset release is ignored, because the FSM is in IDLE.

## Test plan
- Basic fetch: `pc_i`=0x8000_0000, ready=1 always, response 1 cycle after acceptance with data 0x0000_0413 -> `inst_valid_o` at cycle 3, `inst_o`=0x0000_0413, `inst_pc_o`=0x8000_0000, single `pc_we_o` pulse when `inst_ready_i`=1.
- Backpressure:
  - `imem_req_ready_i` low for 3 cycles -> `imem_req_valid_o` and `imem_addr_o` stable throughout.
  - `inst_ready_i` low for 5 cycles -> outputs held and no `pc_we_o` until accepted.
- Misaligned PC 0x8000_0002 -> no `imem_req_valid_o`; `inst_valid_o` at cycle 1 with `inst_fault_o`=1 and `inst_o`=0; `pc_we_o` pulses on accept.
- Bus error: response with `imem_rsp_err_i`=1 and rdata 0xDEAD_BEEF -> `inst_fault_o`=1, `inst_o`=0.
- Flush in WAIT, response 4 cycles later -> DRAIN; that response is dropped with no `inst_valid_o` and no `pc_we_o`; the next fetch of new `pc_i`=0x8000_0100 returns its own data.
- Flush coinciding with an `inst_valid_o`/`inst_ready_i` handshake -> no `pc_we_o` and return to IDLE. Reset asserted in WAIT -> all outputs at reset values asynchronously.
